// File: rtl/arb_mux.sv
// arb_mux: N-channel registered mux with valid/ready on every port.
// Fixed-priority or round-robin arbitration into one output stage.
module arb_mux #(
  parameter int  WIDTH = 32,
  parameter int  N     = 4,
  parameter bit  RR    = 1'b1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] scan_base;
  logic [SEL_W-1:0] gidx;
  logic [SEL_W-1:0] ptr_nxt;
  logic [N-1:0]     grant;
  logic             any_req;
  logic             load_en;

  assign load_en   = !out_valid || out_ready;
  assign any_req   = |in_valid;
  assign scan_base = RR ? ptr : '0;

  // Scan from the far end so the last hit is the first in scan order.
  always_comb begin
    int j;
    grant = '0;
    gidx  = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = int'(scan_base) + k;
      if (j >= N) j = j - N;
      if (in_valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        gidx     = SEL_W'(j);
      end
    end
  end

  assign ptr_nxt = (gidx == SEL_W'(N-1)) ? '0
                 : gidx + SEL_W'(1);

  assign in_ready = grant & {N{load_en & ~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_sel  <= gidx;
        if (RR) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench for round-robin and
// fixed-priority instances of arb_mux.
module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] rr_data, fp_data;
  logic [3:0]   rr_vld, fp_vld;
  logic [3:0]   rr_rdy, fp_rdy;
  logic [31:0]  rr_od, fp_od;
  logic [1:0]   rr_os, fp_os;
  logic         rr_ov, fp_ov;
  logic         rr_ordy, fp_ordy;

  logic [33:0] rr_q[$];
  logic [33:0] fp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int rr_seq[6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .N(4), .RR(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .in_data(rr_data), .in_valid(rr_vld),
    .in_ready(rr_rdy), .out_data(rr_od),
    .out_sel(rr_os), .out_valid(rr_ov),
    .out_ready(rr_ordy)
  );

  arb_mux #(.WIDTH(32), .N(4), .RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .in_data(fp_data), .in_valid(fp_vld),
    .in_ready(fp_rdy), .out_data(fp_od),
    .out_sel(fp_os), .out_valid(fp_ov),
    .out_ready(fp_ordy)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rr_ov && rr_ordy) begin
      chk("rr_q_has_entry", 64'(rr_q.size() != 0), 1);
      if (rr_q.size() != 0)
        chk("rr_word", {rr_os, rr_od}, rr_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && fp_ov && fp_ordy) begin
      chk("fp_q_has_entry", 64'(fp_q.size() != 0), 1);
      if (fp_q.size() != 0)
        chk("fp_word", {fp_os, fp_od}, fp_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    rr_ordy = 1'b1;
    fp_ordy = 1'b1;
    rr_vld  = 4'hF;
    fp_vld  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      rr_data[i*32 +: 32] = 32'h100 + i;
      fp_data[i*32 +: 32] = 32'h200 + i;
    end
    #1;
    chk("rst_rr_rdy0", rr_rdy, 0);
    chk("rst_fp_rdy0", fp_rdy, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_rr_ov", rr_ov, 0);
      chk("rst_rr_od", rr_od, 0);
      chk("rst_rr_os", rr_os, 0);
      chk("rst_rr_rdy", rr_rdy, 0);
      chk("rst_fp_ov", fp_ov, 0);
      chk("rst_fp_rdy", fp_rdy, 0);
    end

    // Round-robin wrap with all channels valid.
    rst    = 1'b0;
    fp_vld = 4'h0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", rr_rdy, 4'b0001 << rr_seq[i]);
      rr_q.push_back({2'(rr_seq[i]),
                      32'(32'h100 + rr_seq[i])});
      step();
      chk("rr_ov", rr_ov, 1);
      chk("rr_os", rr_os, rr_seq[i]);
      chk("rr_od", rr_od, 32'h100 + rr_seq[i]);
    end

    // Idle and drain: ptr must stay at 2.
    rr_vld = 4'h0;
    step();
    chk("idle_ov", rr_ov, 0);
    chk("idle_od_hold", rr_od, 32'h101);
    chk("idle_os_hold", rr_os, 1);
    rr_vld = 4'hF;
    #1;
    chk("idle_ptr_held", rr_rdy, 4'b0100);

    // Back-pressure.
    rr_data[64 +: 32] = 32'hDEAD_BEEF;
    rr_ordy = 1'b0;
    rr_q.push_back({2'd2, 32'hDEAD_BEEF});
    step();
    for (int c = 0; c < 3; c++) begin
      chk("bp_rdy", rr_rdy, 0);
      chk("bp_ov", rr_ov, 1);
      chk("bp_od", rr_od, 32'hDEAD_BEEF);
      chk("bp_os", rr_os, 2);
      step();
    end
    rr_ordy = 1'b1;
    #1;
    chk("bp_release_rdy", rr_rdy, 4'b1000);
    rr_q.push_back({2'd3, 32'h103});
    step();
    chk("bp_nobubble_ov", rr_ov, 1);
    chk("bp_nobubble_od", rr_od, 32'h103);

    // Load ch0 then ch1 so ptr ends at 2.
    chk("mid_grant0", rr_rdy, 4'b0001);
    rr_q.push_back({2'd0, 32'h100});
    step();
    chk("mid_grant1", rr_rdy, 4'b0010);
    step();

    // Reset mid-operation; the held ch1 word is lost.
    rr_ordy = 1'b0;
    rst     = 1'b1;
    #1;
    chk("mid_rst_rdy", rr_rdy, 0);
    chk("mid_held_ov", rr_ov, 1);
    chk("mid_held_os", rr_os, 1);
    step();
    rst = 1'b0;
    chk("mid_rst_ov", rr_ov, 0);
    chk("mid_rst_od", rr_od, 0);
    chk("mid_rst_os", rr_os, 0);
    #1;
    chk("mid_rst_ptr0", rr_rdy, 4'b0001);
    rr_ordy = 1'b1;
    rr_q.push_back({2'd0, 32'h100});
    step();
    rr_vld = 4'h0;
    step();
    step();
    chk("rr_drained", rr_ov, 0);

    // Fixed priority.
    fp_vld  = 4'b1010;
    fp_ordy = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("fp_grant1", fp_rdy, 4'b0010);
      fp_q.push_back({2'd1, 32'h201});
      step();
      chk("fp_os1", fp_os, 1);
    end
    fp_vld = 4'b1000;
    #1;
    chk("fp_grant3", fp_rdy, 4'b1000);
    fp_q.push_back({2'd3, 32'h203});
    step();
    chk("fp_os3", fp_os, 3);
    chk("fp_od3", fp_od, 32'h203);
    fp_vld = 4'h0;
    step();
    step();
    chk("fp_drained", fp_ov, 0);

    chk("rr_q_empty", rr_q.size(), 0);
    chk("fp_q_empty", fp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
